// File: rtl/rom_reader_if.sv
// rom_reader_if: start/burst control, ROM address/data bus and output word stream
// of the ROM read master, with the master's view and its environment's view.
interface rom_reader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_sel;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    modport master (
        input  start, start_addr, count, rom_data, out_ready,
        output rom_addr, rom_sel, out_data, out_valid, busy, done, checksum
    );
    modport slave (
        output start, start_addr, count, rom_data, out_ready,
        input  rom_addr, rom_sel, out_data, out_valid, busy, done, checksum
    );
endinterface

// File: rtl/rom_reader.sv
// rom_reader: walks a wrapping burst of ROM addresses, streams each word over
// valid/ready and keeps a running XOR checksum of the burst.
module rom_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_reader_if.master bus
);
    localparam int CNT_W = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_OUT, S_DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d, sum_q, sum_d;
    logic              valid_q, valid_d, sel_q, sel_d, done_q, done_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                addr_d  = bus.start_addr;
                rem_d   = (bus.count == 0 || bus.count > DEPTH) ? DEPTH : bus.count;
                sum_d   = '0;
                cnt_d   = '0;
                sel_d   = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: if (cnt_q == CNT_W'(SETTLE - 1)) begin
                data_d  = bus.rom_data;
                sum_d   = sum_q ^ bus.rom_data;
                valid_d = 1'b1;
                state_d = S_OUT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_OUT: if (valid_q && bus.out_ready) begin
                valid_d = 1'b0;
                if (rem_q == 1) begin
                    sel_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    // rom_sel is high exactly in SETTLE/OUT, which is the busy window
    assign bus.rom_addr  = addr_q;
    assign bus.rom_sel   = sel_q;
    assign bus.busy      = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.done      = done_q;
    assign bus.checksum  = sum_q;
endmodule

// File: tb/tb_rom_reader.sv
// tb_rom_reader: drives rom_reader against an 8x8 ROM; a burst-level model is
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_rom_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rom_reader_if #(.ADDR_W(3), .DATA_W(8)) bus ();
    rom_reader #(.ADDR_W(3), .DATA_W(8), .SETTLE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    logic [7:0] rom [0:7] = '{8'h01, 8'h03, 8'h09, 8'h31, 8'h71, 8'h39, 8'h41, 8'h81};
    assign bus.rom_data = bus.rom_sel ? rom[bus.rom_addr] : 8'h00;
    int total = 0;
    int bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // burst model: phase 0 idle, 1 burst running, 2 the done cycle
    int ph = 0, base = 0, n = 0, k = 0, wt = 0;
    logic       mv = 1'b0, mdone = 1'b0;
    logic [7:0] md = 8'h00, ms = 8'h00;
    logic [2:0] last = 3'd0;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ph = 0; base = 0; n = 0; k = 0; wt = 0;
            mv = 1'b0; mdone = 1'b0; md = 8'h00; ms = 8'h00; last = 3'd0;
        end else if (ph == 0) begin
            if (bus.start) begin
                base = int'(bus.start_addr);
                n = (bus.count == 0 || int'(bus.count) > 8) ? 8 : int'(bus.count);
                k = 0; wt = 0; ms = 8'h00; ph = 1;
            end
        end else if (ph == 1) begin
            if (mv) begin
                if (bus.out_ready) begin
                    mv = 1'b0;
                    k++;
                    if (k == n) begin
                        ph = 2; mdone = 1'b1; last = 3'((base + n - 1) % 8);
                    end else wt = 0;
                end
            end else begin
                wt++;
                if (wt == 1) begin
                    mv = 1'b1; md = rom[(base + k) % 8]; ms = ms ^ md;
                end
            end
        end else begin
            mdone = 1'b0; ph = 0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("valid", 32'(bus.out_valid), 32'(mv));
            chk("data", 32'(bus.out_data), 32'(md));
            chk("addr", 32'(bus.rom_addr), 32'((ph == 1) ? 3'((base + k) % 8) : last));
            chk("sel", 32'(bus.rom_sel), 32'(ph == 1));
            chk("busy", 32'(bus.busy), 32'(ph == 1));
            chk("done", 32'(bus.done), 32'(mdone));
            chk("checksum", 32'(bus.checksum), 32'(ms));
        end
    end
    // accepted-word collector: outputs are stable from negedge to posedge
    logic [7:0] got [$];
    int dones = 0;
    logic pv = 1'b0;
    logic [7:0] pd = 8'h00;
    initial forever begin
        @(negedge clk);
        if (!rst_n) pv = 1'b0;
        else begin
            if (pv && bus.out_ready) got.push_back(pd);
            if (bus.done) dones++;
            pv = bus.out_valid;
            pd = bus.out_data;
        end
    end
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic go(input logic [2:0] sa, input logic [3:0] c);
        bus.start = 1'b1; bus.start_addr = sa; bus.count = c;
        step();
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input string nm);
        for (int i = 0; i < 200 && !bus.done; i++) step();
        chk({nm, "_done_seen"}, 32'(bus.done), 32'd1);
        step();
    endtask
    task automatic chk_words(input string nm, input logic [7:0] exp [$]);
        chk({nm, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk(nm, (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, 32'(exp[i]));
    endtask
    logic [7:0] eq [$];
    initial begin
        bus.start = 1'b0; bus.start_addr = 3'd0; bus.count = 4'd0; bus.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_sel", 32'(bus.rom_sel), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.checksum), 32'd0);
        rst_n = 1'b1;
        step();
        // full burst from 0
        bus.out_ready = 1'b1; got.delete(); dones = 0;
        go(3'd0, 4'd0);
        wait_done("full");
        eq = '{8'h01, 8'h03, 8'h09, 8'h31, 8'h71, 8'h39, 8'h41, 8'h81};
        chk_words("full_word", eq);
        chk("full_sum", 32'(bus.checksum), 32'hB2);
        chk("full_dones", 32'(dones), 32'd1);
        chk("full_sel_after", 32'(bus.rom_sel), 32'd0);
        // wrapping burst
        got.delete(); dones = 0;
        go(3'd6, 4'd3);
        wait_done("wrap");
        eq = '{8'h41, 8'h81, 8'h01};
        chk_words("wrap_word", eq);
        chk("wrap_sum", 32'(bus.checksum), 32'hC1);
        chk("wrap_dones", 32'(dones), 32'd1);
        // stall on word 3
        got.delete(); dones = 0;
        go(3'd0, 4'd0);
        for (int i = 0; i < 100 && got.size() < 2; i++) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 100 && !bus.out_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", 32'(bus.out_data), 32'h09);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_addr", 32'(bus.rom_addr), 32'd2);
            step();
        end
        bus.out_ready = 1'b1;
        wait_done("stall");
        eq = '{8'h01, 8'h03, 8'h09, 8'h31, 8'h71, 8'h39, 8'h41, 8'h81};
        chk_words("stall_word", eq);
        chk("stall_sum", 32'(bus.checksum), 32'hB2);
        chk("stall_dones", 32'(dones), 32'd1);
        // start mid-burst and during the done cycle
        got.delete(); dones = 0;
        go(3'd0, 4'd5);
        step(); step();
        go(3'd4, 4'd2);
        for (int i = 0; i < 200 && !bus.done; i++) step();
        go(3'd5, 4'd7);
        step(); step();
        eq = '{8'h01, 8'h03, 8'h09, 8'h31, 8'h71};
        chk_words("ign_word", eq);
        chk("ign_sum", 32'(bus.checksum), 32'h4B);
        chk("ign_dones", 32'(dones), 32'd1);
        chk("ign_busy", 32'(bus.busy), 32'd0);
        // reset while word 4 is waiting
        got.delete(); dones = 0;
        go(3'd0, 4'd0);
        for (int i = 0; i < 100 && got.size() < 3; i++) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 100 && !bus.out_valid; i++) step();
        chk("pre_rst_addr", 32'(bus.rom_addr), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("mid_rst_sel", 32'(bus.rom_sel), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_sum", 32'(bus.checksum), 32'd0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("mid_rst_dones", 32'(dones), 32'd0);
        got.delete(); bus.out_ready = 1'b1;
        go(3'd3, 4'd1);
        wait_done("single");
        eq = '{8'h31};
        chk_words("single_word", eq);
        chk("single_sum", 32'(bus.checksum), 32'h31);
        // single word at the top address: latency check
        got.delete(); dones = 0;
        go(3'd7, 4'd1);
        step();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_data", 32'(bus.out_data), 32'h81);
        step();
        chk("lat_done", 32'(bus.done), 32'd1);
        step();
        chk("lat_done_low", 32'(bus.done), 32'd0);
        chk("lat_busy", 32'(bus.busy), 32'd0);
        chk("lat_sum", 32'(bus.checksum), 32'h81);
        // randomized traffic, occasional resets; model checks every cycle
        for (int i = 0; i < 1500; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.start_addr = 3'($urandom);
            bus.count = 4'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end
        bus.start = 1'b0; bus.out_ready = 1'b1;
        repeat (40) step();
        chk("end_busy", 32'(bus.busy), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
